// File: rtl/plab2_mem_secure_responder_pkg.sv
// Memory request/response message layouts, type codes and byte-lane helpers
// shared by the secure memory responder and its response queue.
package plab2_mem_secure_responder_pkg;

    localparam int REQ_MSG_W    = 77;
    localparam int RESP_MSG_W   = 45;
    localparam int RESP_ENTRY_W = RESP_MSG_W + 1;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_t;

    // len of 0 encodes a full 4-byte access
    function automatic logic [3:0] len_mask(input logic [1:0] len);
        logic [3:0] m;
        case (len)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Lanes shifted past byte 3 fall off the 4-bit result, so writes never cross words
    function automatic logic [3:0] lane_mask(input logic [1:0] len, input logic [1:0] offset);
        return len_mask(len) << offset;
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/plab2_mem_resp_queue2.sv
// Two-entry response FIFO; entry0 is always the head, entry1 the tail.
// Output message reads as zero whenever the queue is empty.
module plab2_mem_resp_queue2
    import plab2_mem_secure_responder_pkg::*;
#(
    parameter int p_width = RESP_ENTRY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_msg
);

    logic [1:0]         count;
    logic [p_width-1:0] entry0;
    logic [p_width-1:0] entry1;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_rdy  = (count < 2'd2);
    assign deq_val  = (count != 2'd0);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_msg  = deq_val ? entry0 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, enq_fire} - {1'b0, deq_fire};
        end
    end

    // Storage only needs control to be reset; empty entries are masked on output
    always_ff @(posedge clk) begin
        if (deq_fire) begin
            entry0 <= entry1;
        end
        if (enq_fire) begin
            if (count == 2'd0 || (count == 2'd1 && deq_fire)) begin
                entry0 <= enq_msg;
            end else begin
                entry1 <= enq_msg;
            end
        end
    end

endmodule

// File: rtl/plab2_mem_secure_responder.sv
// Val/rdy memory responder with a secure address window: non-secure accesses
// to the window are answered with zero data, never written, and counted.
module plab2_mem_secure_responder
    import plab2_mem_secure_responder_pkg::*;
#(
    parameter int unsigned p_num_words = 256,
    parameter logic [31:0] p_sec_base  = 32'h0000_0800,
    parameter logic [31:0] p_sec_size  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] req_msg,
    input  logic        req_domain,
    input  logic        req_val,
    output logic        req_rdy,
    output logic [44:0] resp_msg,
    output logic        resp_domain,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic        sec_violation,
    output logic [15:0] violation_count
);

    localparam int          IDX_W   = $clog2(p_num_words);
    localparam logic [32:0] SEC_END = {1'b0, p_sec_base} + {1'b0, p_sec_size};

    logic [31:0]       mem [p_num_words];
    mem_req_t          req;
    mem_resp_t         resp_p0;
    logic              req_fire;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        offset;
    logic              secure_hit;
    logic              violation_p0;
    logic [31:0]       word_rd;
    logic [31:0]       rd_data;
    logic              wr_en;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;
    logic              sec_violation_p1;
    logic [15:0]       violation_count_p1;

    assign req      = req_msg;
    assign req_fire = req_val && req_rdy;
    assign word_idx = req.addr[2 +: IDX_W];
    assign offset   = req.addr[1:0];

    assign secure_hit   = ({1'b0, req.addr} >= {1'b0, p_sec_base}) && ({1'b0, req.addr} < SEC_END);
    assign violation_p0 = secure_hit && !req_domain;

    // Stage 0: request decode, storage access and response build in the accept cycle
    assign word_rd = mem[word_idx];
    assign rd_data = (word_rd >> {offset, 3'b000}) & expand_mask(len_mask(req.len));
    assign wr_en   = req_fire && (req.typ == MEM_WRITE) && !violation_p0;
    assign wr_mask = lane_mask(req.len, offset);
    assign wr_data = req.data << {offset, 3'b000};

    always_comb begin
        resp_p0.typ    = req.typ;
        resp_p0.opaque = req.opaque;
        resp_p0.len    = req.len;
        resp_p0.data   = '0;
        if (req.typ == MEM_READ && !violation_p0) begin
            resp_p0.data = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Stage 1: violation pulse and saturating counter, aligned with the queued response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_violation_p1   <= 1'b0;
            violation_count_p1 <= 16'h0000;
        end else begin
            sec_violation_p1 <= req_fire && violation_p0;
            if (req_fire && violation_p0 && violation_count_p1 != 16'hFFFF) begin
                violation_count_p1 <= violation_count_p1 + 16'd1;
            end
        end
    end

    assign sec_violation   = sec_violation_p1;
    assign violation_count = violation_count_p1;

    plab2_mem_resp_queue2 #(
        .p_width (RESP_ENTRY_W)
    ) u_resp_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (req_val),
        .enq_rdy (req_rdy),
        .enq_msg ({resp_p0, req_domain}),
        .deq_val (resp_val),
        .deq_rdy (resp_rdy),
        .deq_msg ({resp_msg, resp_domain})
    );

endmodule

// File: tb/tb_plab2_mem_secure_responder.sv
// Directed bench for the secure memory responder: word/subword access, secure
// blocking, backpressure, streaming and asynchronous reset mid-flight.
module tb_plab2_mem_secure_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [76:0] req_msg;
    logic        req_domain;
    logic        req_val;
    logic        req_rdy;
    logic [44:0] resp_msg;
    logic        resp_domain;
    logic        resp_val;
    logic        resp_rdy;
    logic        sec_violation;
    logic [15:0] violation_count;

    int tests = 0;
    int fails = 0;
    logic [46:0] exp_v;

    plab2_mem_secure_responder dut (
        .clk             (clk),
        .reset           (reset),
        .req_msg         (req_msg),
        .req_domain      (req_domain),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .resp_msg        (resp_msg),
        .resp_domain     (resp_domain),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .sec_violation   (sec_violation),
        .violation_count (violation_count)
    );

    always #5 clk = ~clk;

    // Offers one request from #1 after a posedge, returns #1 after the accepting edge
    task automatic issue(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] d, input logic dom);
        int waited;
        req_msg    = {t, op, addr, len, d};
        req_domain = dom;
        req_val    = 1'b1;
        waited     = 0;
        while (!req_rdy && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_rdy) begin
            tests++; fails++;
            $display("FAIL issue_timeout: req_rdy=%0b after %0d cycles, required 1", req_rdy, waited);
        end
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if ({resp_val, req_rdy, sec_violation} !== 3'b010) begin fails++;
            $display("FAIL reset_ctrl: got val/rdy/viol=%b required 010", {resp_val, req_rdy, sec_violation}); end
        tests++; if (violation_count !== 16'h0000) begin fails++;
            $display("FAIL reset_count: got %h required 0000", violation_count); end
        tests++; if ({resp_domain, resp_msg} !== 46'h0) begin fails++;
            $display("FAIL reset_msg: got %h required 0", {resp_domain, resp_msg}); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        tests++; if ({resp_val, req_rdy} !== 2'b01) begin fails++;
            $display("FAIL reset_release: got val/rdy=%b required 01", {resp_val, req_rdy}); end
    endtask

    task automatic test_word_rw();
        issue(3'd1, 8'h05, 32'h10, 2'd0, 32'hDEADBEEF, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd1, 8'h05, 2'd0, 32'h0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL word_wr_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h06, 32'h10, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h06, 2'd0, 32'hDEADBEEF};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL word_rd_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
        tests++; if (resp_val !== 1'b0) begin fails++;
            $display("FAIL word_drain: got resp_val=%b required 0", resp_val); end
    endtask

    task automatic test_subword();
        issue(3'd1, 8'h10, 32'h10, 2'd0, 32'h11223344, 1'b1);
        issue(3'd1, 8'h11, 32'h13, 2'd1, 32'h000000AB, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd1, 8'h11, 2'd1, 32'h0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_wr_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h12, 32'h10, 2'd0, 32'h0, 1'b0);
        exp_v = {1'b1, 1'b0, 3'd0, 8'h12, 2'd0, 32'hAB223344};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_rd_word: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h13, 32'h12, 2'd2, 32'h0, 1'b0);
        exp_v = {1'b1, 1'b0, 3'd0, 8'h13, 2'd2, 32'h0000AB22};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_rd_half: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h14, 32'h11, 2'd3, 32'h0, 1'b0);
        exp_v = {1'b1, 1'b0, 3'd0, 8'h14, 2'd3, 32'h00AB2233};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_rd_3byte: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h15, 32'h410, 2'd0, 32'h0, 1'b0);
        exp_v = {1'b1, 1'b0, 3'd0, 8'h15, 2'd0, 32'hAB223344};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_rd_wrap: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd1, 8'h16, 32'h18, 2'd0, 32'h12345678, 1'b1);
        issue(3'd1, 8'h17, 32'h14, 2'd0, 32'h00000000, 1'b1);
        issue(3'd1, 8'h18, 32'h17, 2'd2, 32'h0000CCDD, 1'b1);
        issue(3'd0, 8'h19, 32'h14, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h19, 2'd0, 32'hDD000000};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_lane_drop: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h1A, 32'h18, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h1A, 2'd0, 32'h12345678};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sub_no_cross: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_other_type();
        issue(3'd2, 8'h30, 32'h10, 2'd0, 32'hFFFFFFFF, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd2, 8'h30, 2'd0, 32'h0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL other_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd7, 8'h31, 32'h10, 2'd1, 32'hFFFFFFFF, 1'b1);
        issue(3'd0, 8'h32, 32'h10, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h32, 2'd0, 32'hAB223344};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL other_no_write: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_secure_block();
        issue(3'd1, 8'h40, 32'h800, 2'd0, 32'h00000055, 1'b1);
        tests++; if (sec_violation !== 1'b0) begin fails++;
            $display("FAIL sec_own_write: got sec_violation=%b required 0", sec_violation); end
        issue(3'd1, 8'h41, 32'h800, 2'd0, 32'h00000099, 1'b0);
        tests++; if ({sec_violation, violation_count} !== {1'b1, 16'd1}) begin fails++;
            $display("FAIL sec_ns_write_viol: got viol=%b count=%0d required 1/1", sec_violation, violation_count); end
        exp_v = {1'b1, 1'b0, 3'd1, 8'h41, 2'd0, 32'h0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sec_ns_write_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h42, 32'h800, 2'd0, 32'h0, 1'b0);
        tests++; if ({sec_violation, violation_count} !== {1'b1, 16'd2}) begin fails++;
            $display("FAIL sec_ns_read_viol: got viol=%b count=%0d required 1/2", sec_violation, violation_count); end
        exp_v = {1'b1, 1'b0, 3'd0, 8'h42, 2'd0, 32'h0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sec_ns_read_resp: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
        tests++; if ({sec_violation, violation_count} !== {1'b0, 16'd2}) begin fails++;
            $display("FAIL sec_pulse_end: got viol=%b count=%0d required 0/2", sec_violation, violation_count); end
        issue(3'd0, 8'h43, 32'h800, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h43, 2'd0, 32'h00000055};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sec_read_back: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd1, 8'h44, 32'h900, 2'd0, 32'h00000077, 1'b0);
        tests++; if (sec_violation !== 1'b0) begin fails++;
            $display("FAIL sec_above_end: got sec_violation=%b required 0", sec_violation); end
        issue(3'd0, 8'h45, 32'h900, 2'd0, 32'h0, 1'b0);
        exp_v = {1'b1, 1'b0, 3'd0, 8'h45, 2'd0, 32'h00000077};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL sec_above_read: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        issue(3'd0, 8'h46, 32'h8FC, 2'd0, 32'h0, 1'b0);
        tests++; if ({sec_violation, violation_count, resp_msg[31:0]} !== {1'b1, 16'd3, 32'h0}) begin fails++;
            $display("FAIL sec_last_word: got viol=%b count=%0d data=%h required 1/3/0", sec_violation, violation_count, resp_msg[31:0]); end
        issue(3'd0, 8'h47, 32'h7FC, 2'd0, 32'h0, 1'b0);
        tests++; if ({sec_violation, violation_count} !== {1'b0, 16'd3}) begin fails++;
            $display("FAIL sec_below_base: got viol=%b count=%0d required 0/3", sec_violation, violation_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        resp_rdy   = 1'b0;
        req_domain = 1'b1;
        req_msg    = {3'd0, 8'h21, 32'h10, 2'd0, 32'h0};
        req_val    = 1'b1;
        @(posedge clk); #1;
        tests++; if ({resp_val, req_rdy} !== 2'b11) begin fails++;
            $display("FAIL bp_first: got val/rdy=%b required 11", {resp_val, req_rdy}); end
        req_msg = {3'd0, 8'h22, 32'h800, 2'd0, 32'h0};
        @(posedge clk); #1;
        tests++; if (req_rdy !== 1'b0) begin fails++;
            $display("FAIL bp_full: got req_rdy=%b required 0", req_rdy); end
        req_msg = {3'd0, 8'h23, 32'h900, 2'd0, 32'h0};
        @(posedge clk); #1;
        exp_v = {1'b1, 1'b1, 3'd0, 8'h21, 2'd0, 32'hAB223344};
        tests++; if ({req_rdy, resp_val, resp_domain, resp_msg} !== {1'b0, exp_v}) begin fails++;
            $display("FAIL bp_stall: got rdy=%b head=%h required 0/%h", req_rdy, {resp_val, resp_domain, resp_msg}, exp_v); end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        exp_v = {1'b1, 1'b1, 3'd0, 8'h22, 2'd0, 32'h00000055};
        tests++; if ({req_rdy, resp_val, resp_domain, resp_msg} !== {1'b1, exp_v}) begin fails++;
            $display("FAIL bp_drain1: got rdy=%b head=%h required 1/%h", req_rdy, {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
        req_val = 1'b0;
        exp_v = {1'b1, 1'b1, 3'd0, 8'h23, 2'd0, 32'h00000077};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL bp_third: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
        tests++; if (resp_val !== 1'b0) begin fails++;
            $display("FAIL bp_empty: got resp_val=%b required 0", resp_val); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        addrs = '{32'h10, 32'h14, 32'h18, 32'h900};
        datas = '{32'hAB223344, 32'hDD000000, 32'h12345678, 32'h00000077};
        resp_rdy   = 1'b1;
        req_domain = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_msg = {3'd0, 8'h60 + 8'(i), addrs[i], 2'd0, 32'h0};
            req_val = 1'b1;
            @(posedge clk); #1;
            exp_v = {1'b1, 1'b0, 3'd0, 8'h60 + 8'(i), 2'd0, datas[i]};
            tests++; if ({req_rdy, resp_val, resp_domain, resp_msg} !== {1'b1, exp_v}) begin fails++;
                $display("FAIL stream_%0d: got rdy=%b head=%h required 1/%h", i, req_rdy, {resp_val, resp_domain, resp_msg}, exp_v); end
        end
        req_val = 1'b0;
        @(posedge clk); #1;
        tests++; if (resp_val !== 1'b0) begin fails++;
            $display("FAIL stream_drain: got resp_val=%b required 0", resp_val); end
    endtask

    task automatic test_reset_midflight();
        resp_rdy = 1'b0;
        issue(3'd0, 8'h50, 32'h800, 2'd0, 32'h0, 1'b0);
        issue(3'd0, 8'h51, 32'h10, 2'd0, 32'h0, 1'b1);
        tests++; if ({resp_val, req_rdy, violation_count} !== {2'b10, 16'd4}) begin fails++;
            $display("FAIL mid_queued: got val/rdy=%b count=%0d required 10/4", {resp_val, req_rdy}, violation_count); end
        #2; reset = 1'b0;
        #1;
        tests++; if ({resp_val, req_rdy, sec_violation, violation_count} !== {3'b010, 16'd0}) begin fails++;
            $display("FAIL mid_async: got val/rdy/viol=%b count=%0d required 010/0", {resp_val, req_rdy, sec_violation}, violation_count); end
        tests++; if ({resp_domain, resp_msg} !== 46'h0) begin fails++;
            $display("FAIL mid_msg: got %h required 0", {resp_domain, resp_msg}); end
        @(negedge clk); reset = 1'b1; resp_rdy = 1'b1;
        @(posedge clk); #1;
        tests++; if ({resp_val, req_rdy} !== 2'b01) begin fails++;
            $display("FAIL mid_release: got val/rdy=%b required 01", {resp_val, req_rdy}); end
        issue(3'd1, 8'h52, 32'h20, 2'd0, 32'h2468ACE0, 1'b1);
        issue(3'd0, 8'h53, 32'h20, 2'd0, 32'h0, 1'b1);
        exp_v = {1'b1, 1'b1, 3'd0, 8'h53, 2'd0, 32'h2468ACE0};
        tests++; if ({resp_val, resp_domain, resp_msg} !== exp_v) begin fails++;
            $display("FAIL mid_resume: got %h required %h", {resp_val, resp_domain, resp_msg}, exp_v); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset      = 1'b0;
        req_msg    = '0;
        req_domain = 1'b0;
        req_val    = 1'b0;
        resp_rdy   = 1'b1;
        test_reset();
        test_word_rw();
        test_subword();
        test_other_type();
        test_secure_block();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/plab2_mem_secure_responder.md
Name: plab2_mem_secure_responder

Overview:
- Memory-side responder for the processor's val/rdy memory request/response interface.
- Accepts packed memory request messages, services them from an internal word array, and returns packed response messages.
- Enforces a TrustZone-style secure region: non-secure requests to secure addresses are blocked and logged.
- Used as the data/instruction memory endpoint behind the processor in simulation and in synthesis test harnesses.

Parameters:
- p_num_words, 256, depth of storage in 32-bit words; power of two, at least 4.
- p_sec_base, 32'h0000_0800, byte address of the first secure byte; word-aligned.
- p_sec_size, 32'h0000_0100, secure region size in bytes; a nonzero multiple of 4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_msg  in  77  request message {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}.
- req_domain  in  1  security domain of the request: 1 = secure, 0 = non-secure.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- resp_msg  out  45  response message {type[44:42], opaque[41:34], len[33:32], data[31:0]}.
- resp_domain  out  1  domain of the request that produced this response.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- sec_violation  out  1  one-cycle pulse on a blocked access.
- violation_count  out  16  count of blocked accesses.

Behaviour:
- Reset, asserted low and asynchronous: storage contents are undefined. Queue is empty, so resp_val=0 and req_rdy=1. sec_violation=0, violation_count=0, resp_msg=0, resp_domain=0.
- Handshakes:
  - A request fires when req_val && req_rdy.
  - A response fires when resp_val && resp_rdy.
  - resp_val does not depend combinationally on resp_rdy.
- Response queue:
  - 2-entry FIFO holding {resp_msg, resp_domain}.
  - req_rdy = (count < 2). It is a registered-count decision with no full-bypass.
- Latency: a request accepted in cycle N is visible at the queue head no earlier than cycle N+1. resp_val rises in N+1 if the queue was empty.
- Simultaneous enqueue and dequeue: count is unchanged and entry order is preserved.
- Ordering: responses return in request order.
- Indexing:
  - word index = addr[2 +: log2(p_num_words)]; higher address bits wrap.
  - byte offset = addr[1:0].
- len encoding: 0 means 4 bytes; 1 to 3 mean that many bytes.
- Write (type=1):
  - Byte lanes offset through offset+nbytes-1 are written, taken from data low bytes upward.
  - Lanes beyond byte 3 are dropped; there is no crossing into the next word.
  - Response data is 0.
- Read (type=0): data = (word >> 8*offset), masked to nbytes.
- Other types: no storage change; response data is 0.
- Response fields: type, opaque and len echo the request.
- Security check:
  - secure_hit = (addr >= p_sec_base) && (addr < p_sec_base + p_sec_size).
  - A violation is secure_hit && req_domain == 0. The write is suppressed and read data is forced to 0.
  - A response is still returned, so there is no deadlock.
  - sec_violation pulses in cycle N+1.
  - violation_count increments in N+1 and saturates at 16'hFFFF.
- Secure-domain requests may access all addresses.
- Storage timing: writes commit at the clock edge that accepts the request. A read accepted in the following cycle sees the new data.
- Reset mid-operation: queued responses are discarded and counters cleared. After release, requests accepted pre-reset produce no response.

Decomposition:
- Shared package / include: message field widths and offsets, plus type codes READ=3'd0 and WRITE=3'd1. Use the existing vc-mem-msgs definitions where present.
- Local constants: byte-mask generation helper.
- Sub-module: plab2_mem_resp_queue2, a 2-entry FIFO on {resp_msg, resp_domain} with async active-low reset.

Test Plan:
- Word write/read: secure write, addr 0x10, len 0, data 0xDEADBEEF, opaque 0x05; then read addr 0x10. Expect response 1 with type 1, opaque 0x05, data 0. Expect response 2 with data 0xDEADBEEF, each one cycle after acceptance.
- Subword access:
  - Write byte 0xAB to addr 0x13, len 1, over prior 0x11223344. Then read addr 0x10 len 0, expecting 0xAB223344.
  - Read addr 0x12 len 2, expecting 0x0000AB22.
- Secure block:
  - Secure write 0x55 to 0x800. Then non-secure write 0x99 to 0x800 and non-secure read of 0x800.
  - Non-secure read returns 0; sec_violation pulses twice; violation_count=2.
  - A subsequent secure read returns 0x00000055.
- Backpressure:
  - Hold resp_rdy=0 and offer 3 back-to-back reads. Expect req_rdy=0 after 2 accepts.
  - Raise resp_rdy: responses drain in order and the third request is accepted the cycle after the count drops.
- Simultaneous enq/deq: streaming reads with resp_rdy=1 sustain 1 request/cycle, with count steady at 1.
- Reset mid-flight: 2 queued responses, assert reset low asynchronously between clock edges. Expect immediate resp_val=0 and violation_count=0. After release, req_rdy=1.
